// File: rtl/ad7822_reader.sv
`default_nettype none
// ============================================================================
// Module   : ad7822_reader
// Brief    : AD7822 sampling controller that periodically converts, reads the
//            parallel result and presents raw and boxcar-averaged codes.
// Revision : 1.0
// ============================================================================
module ad7822_reader #(
  parameter int SAMPLE_DIV  = 500,
  parameter int CONVST_LOW  = 3,
  parameter int RD_SETUP    = 3,
  parameter int EOC_TIMEOUT = 64,
  parameter int AVG_LOG2    = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic       i_EOC_n,
  input  logic [7:0] i_DB,
  output logic       o_CONVST_n,
  output logic       o_CS_n,
  output logic       o_RD_n,
  output logic [7:0] o_data,
  output logic [7:0] o_data_avg,
  output logic       o_valid,
  output logic       o_timeout,
  output logic       o_overrun
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = 8 + AVG_LOG2;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int PH_MX1 = (CONVST_LOW > RD_SETUP) ? CONVST_LOW : RD_SETUP;
  localparam int PH_MAX = (PH_MX1 > EOC_TIMEOUT) ? PH_MX1 : EOC_TIMEOUT;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONVST   = 3'd1,
    S_WAIT_EOC = 3'd2,
    S_READ     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           state_q;
  logic [PH_W-1:0]  ph_q;
  logic [DIV_W-1:0] div_q;
  logic             eoc_meta_q;
  logic             eoc_s_q;
  logic             convst_n_q;
  logic             cs_n_q;
  logic             valid_q;
  logic             timeout_q;
  logic             overrun_q;
  logic [7:0]       data_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic [7:0]       hist_q [DEPTH];
  logic             w_tick;

  // EOC is asynchronous to this clock domain
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      eoc_meta_q <= 1'b1;
      eoc_s_q    <= 1'b1;
    end else begin
      eoc_meta_q <= i_EOC_n;
      eoc_s_q    <= eoc_meta_q;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_enable) begin
      div_q <= '0;
    end else if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign w_tick = i_enable && (div_q == DIV_W'(SAMPLE_DIV - 1));

  // The oldest code leaves the window as the new one enters, so the sum
  // can never exceed DEPTH * 255.
  assign sum_d = sum_q + SUM_W'(i_DB) - SUM_W'(hist_q[DEPTH-1]);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      convst_n_q <= 1'b1;
      cs_n_q     <= 1'b1;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      data_q     <= '0;
      sum_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      if (i_clear) begin
        timeout_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (w_tick && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (w_tick) begin
            state_q    <= S_CONVST;
            convst_n_q <= 1'b0;
            ph_q       <= '0;
          end
        end
        S_CONVST: begin
          if (ph_q == PH_W'(CONVST_LOW - 1)) begin
            state_q    <= S_WAIT_EOC;
            convst_n_q <= 1'b1;
            ph_q       <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        S_WAIT_EOC: begin
          if (!eoc_s_q) begin
            state_q <= S_READ;
            cs_n_q  <= 1'b0;
            ph_q    <= '0;
          end else if (ph_q == PH_W'(EOC_TIMEOUT - 1)) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b1;
            ph_q      <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        S_READ: begin
          if (ph_q == PH_W'(RD_SETUP - 1)) begin
            state_q   <= S_DONE;
            cs_n_q    <= 1'b1;
            valid_q   <= 1'b1;
            data_q    <= i_DB;
            sum_q     <= sum_d;
            hist_q[0] <= i_DB;
            for (int i = 1; i < DEPTH; i++) begin
              hist_q[i] <= hist_q[i-1];
            end
            ph_q <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_CONVST_n = convst_n_q;
  assign o_CS_n     = cs_n_q;
  assign o_RD_n     = cs_n_q;
  assign o_data     = data_q;
  assign o_data_avg = 8'(sum_q >> AVG_LOG2);
  assign o_valid    = valid_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ad7822_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad7822_reader
// Brief    : Bench with an ADC model, a reference averager and a scoreboard,
//            plus a short-period instance for the overrun behaviour.
// Revision : 1.0
// ============================================================================
module tb_ad7822_reader;

  localparam int AVG_LOG2 = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int RD_SETUP = 3;

  typedef struct {
    int data;
    int avg;
    int at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       eoc_n = 1'b1;
  logic [7:0] db = 8'h00;
  logic       conv_n, cs_n, rd_n, valid, tmo, ovr;
  logic [7:0] data, avg;

  logic       en2 = 1'b0;
  logic       eoc2_n = 1'b1;
  logic [7:0] db2 = 8'h00;
  logic       conv2_n, cs2_n, rd2_n, valid2, tmo2, ovr2;
  logic [7:0] data2, avg2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sb[$];
  int   hist[$];

  ad7822_reader u_dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_clear(clr),
    .i_EOC_n(eoc_n), .i_DB(db),
    .o_CONVST_n(conv_n), .o_CS_n(cs_n), .o_RD_n(rd_n),
    .o_data(data), .o_data_avg(avg), .o_valid(valid),
    .o_timeout(tmo), .o_overrun(ovr)
  );

  ad7822_reader #(.SAMPLE_DIV(32)) u_ovr (
    .i_clock(clk), .i_reset(rst), .i_enable(en2), .i_clear(clr),
    .i_EOC_n(eoc2_n), .i_DB(db2),
    .o_CONVST_n(conv2_n), .o_CS_n(cs2_n), .o_RD_n(rd2_n),
    .o_data(data2), .o_data_avg(avg2), .o_valid(valid2),
    .o_timeout(tmo2), .o_overrun(ovr2)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ADC model: EOC falls a chosen number of cycles after CONVST falls and
  // returns high once the read strobe is seen.
  int         delay_fixed = 10;
  int         force_code = 8'h80;
  bit         eoc_never = 1'b0;
  logic       conv_prev = 1'b1;
  bit         armed = 1'b0;
  int         eoc_at = 0;
  logic [7:0] pend = 8'h00;
  int         fall_cnt = 0;
  int         last_fall = 0;

  always @(negedge clk) begin : adc_model
    int   d;
    int   s;
    exp_t e;
    if (rst) begin
      eoc_n     = 1'b1;
      armed     = 1'b0;
      conv_prev = 1'b1;
      hist.delete();
    end else begin
      if (armed && cyc == eoc_at) begin
        eoc_n = 1'b0;
        db    = pend;
        armed = 1'b0;
      end
      if (!rd_n) eoc_n = 1'b1;
      if (conv_prev && !conv_n) begin
        fall_cnt++;
        last_fall = cyc;
        if (!eoc_never) begin
          d      = (delay_fixed > 0) ? delay_fixed : int'($urandom_range(40, 1));
          pend   = (force_code >= 0) ? 8'(force_code) : 8'($urandom_range(255, 0));
          armed  = 1'b1;
          eoc_at = cyc + d;
          hist.push_back(int'(pend));
          if (hist.size() > DEPTH) void'(hist.pop_front());
          s = 0;
          foreach (hist[i]) s += hist[i];
          e.data = int'(pend);
          e.avg  = s / DEPTH;
          e.at   = cyc + d + 3 + RD_SETUP;
          sb.push_back(e);
        end
      end
      conv_prev = conv_n;
    end
  end

  int   valid_cnt = 0;
  int   last_data = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      valid_prev = 1'b0;
      last_data  = 0;
    end else begin
      if (!cs_n || !rd_n) check("strobe_overlap", int'(conv_n), 1);
      if (valid) begin
        valid_cnt++;
        check("valid_back_to_back", int'(valid_prev), 0);
        check("sb_has_entry", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data", int'(data), e.data);
          check("data_avg", int'(avg), e.avg);
          check("valid_cycle", cyc, e.at);
          last_data = e.data;
        end
      end
      valid_prev = valid;
    end
  end

  // Second ADC model and monitor for the short-period instance.
  logic conv2_prev = 1'b1;
  bit   armed2 = 1'b0;
  int   eoc2_at = 0;
  int   fall2_cnt = 0;
  int   fall2_prev = 0;
  int   first_fall2 = 0;
  int   valid2_cnt = 0;

  always @(negedge clk) begin : adc2_model
    if (rst) begin
      eoc2_n     = 1'b1;
      armed2     = 1'b0;
      conv2_prev = 1'b1;
    end else begin
      if (armed2 && cyc == eoc2_at) begin
        eoc2_n = 1'b0;
        db2    = 8'h5A;
        armed2 = 1'b0;
      end
      if (!rd2_n) eoc2_n = 1'b1;
      if (!cs2_n) check("ovr_strobe_overlap", int'(conv2_n), 1);
      if (valid2) begin
        valid2_cnt++;
        check("ovr_data", int'(data2), 8'h5A);
      end
      if (conv2_prev && !conv2_n) begin
        if (fall2_cnt == 0) first_fall2 = cyc;
        else check("ovr_fall_spacing", cyc - fall2_prev, 64);
        fall2_prev = cyc;
        fall2_cnt++;
        armed2  = 1'b1;
        eoc2_at = cyc + 40;
      end
      conv2_prev = conv2_n;
    end
  end

  task automatic wait_fall_after(input int n0, input int budget, input string name);
    int k;
    k = 0;
    while (fall_cnt <= n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(fall_cnt > n0), 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic wait_conv_high(input int budget);
    int k;
    k = 0;
    while (!conv_n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("convst_release", int'(conv_n), 1);
  endtask

  initial begin : stimulus
    int e0, prev, k, vc, fc, w0, r0, e2, n;
    int codes[8];
    codes = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h00};

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_convst_n", int'(conv_n), 1);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_rd_n", int'(rd_n), 1);
    check("rst_data", int'(data), 0);
    check("rst_avg", int'(avg), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(tmo), 0);
    check("rst_overrun", int'(ovr), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Fixed code and EOC delay, then the alternating full-scale pattern.
    delay_fixed = 10;
    force_code  = codes[0];
    en = 1'b1;
    e0 = cyc;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      force_code = codes[i];
      n = fall_cnt;
      wait_fall_after(n, 600, "fall_fixed");
      if (i == 0) check("first_tick_cycle", last_fall, e0 + 500);
      else        check("sample_period", last_fall - prev, 500);
      prev = last_fall;
    end
    wait_drain(100, "drain_fixed");
    check("avg_settled", int'(avg), 8'h7F);

    // Random codes and random EOC delays.
    delay_fixed = 0;
    force_code  = -1;
    for (int i = 0; i < 10; i++) begin
      n = fall_cnt;
      wait_fall_after(n, 600, "fall_random");
    end
    wait_drain(100, "drain_random");

    // EOC never arrives.
    eoc_never = 1'b1;
    vc = valid_cnt;
    n  = fall_cnt;
    wait_fall_after(n, 600, "fall_timeout");
    wait_conv_high(20);
    w0 = cyc;
    k  = 0;
    while (!tmo && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", cyc - w0, 64);
    check("timeout_no_valid", valid_cnt, vc);
    check("timeout_data_kept", int'(data), last_data);
    eoc_never   = 1'b0;
    delay_fixed = 10;
    n = fall_cnt;
    wait_fall_after(n, 600, "fall_after_timeout");
    wait_drain(100, "drain_after_timeout");
    check("timeout_sticky", int'(tmo), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("timeout_cleared", int'(tmo), 0);

    // Reset pulsed while the read strobe is low.
    n = fall_cnt;
    wait_fall_after(n, 600, "fall_before_reset");
    k = 0;
    while (rd_n && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached_read", int'(rd_n), 0);
    rst = 1'b1;
    r0  = cyc;
    @(negedge clk);
    check("rr_cs_n", int'(cs_n), 1);
    check("rr_rd_n", int'(rd_n), 1);
    check("rr_convst_n", int'(conv_n), 1);
    check("rr_data", int'(data), 0);
    check("rr_avg", int'(avg), 0);
    check("rr_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    n = fall_cnt;
    wait_fall_after(n, 700, "fall_after_reset");
    check("resume_cycle", last_fall, r0 + 502);

    // Drop enable while waiting for EOC.
    wait_conv_high(20);
    en = 1'b0;
    vc = valid_cnt;
    fc = fall_cnt;
    repeat (1500) @(negedge clk);
    check("disable_valid_completes", valid_cnt, vc + 1);
    check("disable_no_more_ticks", fall_cnt, fc);
    check("disable_sb_empty", sb.size(), 0);
    check("main_no_overrun", int'(ovr), 0);

    // Short sample period with a long conversion forces dropped ticks.
    en2 = 1'b1;
    e2  = cyc;
    repeat (400) @(negedge clk);
    en2 = 1'b0;
    repeat (100) @(negedge clk);
    check("ovr_first_fall", first_fall2, e2 + 32);
    check("ovr_fall_count", fall2_cnt, 6);
    check("ovr_valid_count", valid2_cnt, fall2_cnt);
    check("ovr_flag", int'(ovr2), 1);
    check("ovr_no_timeout", int'(tmo2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ad7822_reader.md
# ad7822_reader

Sampling controller for one AD7822 8-bit ADC in the rectifier sensing path. It periodically starts a conversion, waits for end-of-conversion, and reads the parallel result. It presents both a raw code and a boxcar-averaged code, with a one-cycle valid strobe. Its outputs feed the battery current/voltage sensing blocks directly: one instance for the Ibat channel, one for the Vbat channel.

## Interface
Parameters:
- SAMPLE_DIV, 500: clock cycles per sample period (100 kS/s at 50 MHz); legal range ≥ 32.
- CONVST_LOW, 3: cycles o_CONVST_n is held low; legal range ≥ 2.
- RD_SETUP, 3: cycles o_CS_n/o_RD_n are low before data capture; legal range ≥ 2.
- EOC_TIMEOUT, 64: maximum cycles spent waiting for EOC.
- AVG_LOG2, 2: log2 of averaging depth (4 samples); legal range 0–4.

Ports:
- i_clock  in  1  system clock (50 MHz)
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  enables periodic sampling
- i_clear  in  1  clears sticky flags
- i_EOC_n  in  1  ADC end-of-conversion, asynchronous, active low
- i_DB  in  8  ADC data bus
- o_CONVST_n  out  1  conversion start, active low
- o_CS_n  out  1  chip select, active low
- o_RD_n  out  1  read strobe, active low
- o_data  out  8  last raw code
- o_data_avg  out  8  boxcar average of last 2^AVG_LOG2 codes
- o_valid  out  1  one-cycle pulse when o_data/o_data_avg update
- o_timeout  out  1  sticky: EOC never arrived
- o_overrun  out  1  sticky: sample tick while FSM busy

## Operation
- Reset values: o_CONVST_n=1, o_CS_n=1, o_RD_n=1, o_data=0, o_data_avg=0, o_valid=0, o_timeout=0, o_overrun=0. Reset also clears the period counter, FSM (IDLE), sum, and history.
- i_EOC_n passes through a 2-FF synchronizer (eoc_s). The synchronizer resets to 1.
- Period counter:
  - Counts 0..SAMPLE_DIV-1 while i_enable=1 and wraps to 0.
  - Held at 0 while i_enable=0.
  - A tick occurs at count SAMPLE_DIV-1.
- FSM states:
  - IDLE: on tick, go to CONVST.
  - CONVST: o_CONVST_n=0 for CONVST_LOW cycles, then go to WAIT_EOC.
  - WAIT_EOC: o_CONVST_n=1. If eoc_s=0, go to READ. Else, once EOC_TIMEOUT cycles have elapsed, set o_timeout and go to IDLE (no valid; o_data and average unchanged).
  - READ: o_CS_n=0 and o_RD_n=0 for RD_SETUP cycles. i_DB is registered on the clock edge that ends the last READ cycle. Then go to DONE.
  - DONE: o_CS_n=1, o_RD_n=1, o_valid=1 for one cycle, then go to IDLE.
- Tick while state ≠ IDLE: set o_overrun; the tick is dropped (no queuing).
- Dropping i_enable mid-conversion: the conversion in progress completes normally (valid is still produced). No further ticks are issued.
- Sticky flags:
  - Cleared when i_clear=1.
  - If a set event and i_clear coincide in the same cycle, set wins.
- Averaging:
  - History is a shift register of 2^AVG_LOG2 codes, initialised to 0.
  - Running sum is (8+AVG_LOG2) bits: sum ← sum + new − oldest, with no overflow possible.
  - o_data_avg = sum >> AVG_LOG2 (truncation).
  - Until history fills, the average ramps up from 0; no masking is applied.
  - AVG_LOG2=0 gives o_data_avg = o_data.

## Timing
- Tick at cycle T: o_CONVST_n is low during cycles T+1..T+CONVST_LOW.
- eoc_s follows i_EOC_n with 2-cycle latency. If i_EOC_n falls before edge E, READ begins 3 cycles after the cycle in which i_EOC_n is first sampled low.
- READ lasts exactly RD_SETUP cycles. o_data, o_data_avg, and o_valid are all updated in the same DONE cycle, immediately after READ.
- Total latency from tick to o_valid = CONVST_LOW + (EOC wait incl. sync) + RD_SETUP + 1 cycles.
- o_CS_n and o_RD_n are never low in the same cycle as o_CONVST_n.
- o_valid is never asserted on two consecutive cycles.
- Reset asserted mid-operation: all outputs take their reset values on the next edge. The ADC strobes release within one cycle.

## Test plan
- ADC model drops EOC 10 cycles after o_CONVST_n falls and drives DB=0x80, defaults used -> one valid per 500 cycles; o_data=0x80; o_data_avg=0x20, 0x40, 0x60, 0x80 over the first four samples.
- Sample sequence 0xFF, 0x00, 0xFF, 0x00, AVG_LOG2=2 -> o_data_avg settles at 0x7F; sum never exceeds 0x3FC.
- EOC held high -> o_timeout=1 exactly 64 cycles after entering WAIT_EOC; no o_valid; o_data unchanged. Next tick starts normally. i_clear drops the flag.
- SAMPLE_DIV=32 with EOC delay 40 cycles -> o_overrun=1; every other tick is dropped; no strobe overlap.
- Reset pulsed during READ -> next cycle o_CS_n=o_RD_n=1, o_data=0, state IDLE; sampling resumes after SAMPLE_DIV cycles.
- i_enable deasserted during WAIT_EOC -> that sample completes with o_valid; no further o_CONVST_n pulses.
